// File: rtl/datatype_package.sv
// ============================================================================
// Module      : datatype_package
// Description : Shared types for the 7-segment display path (segment pattern,
//               digit count default, scanner state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package datatype_package;

    typedef logic [7:0] seg8_t;

    localparam int SEG7_DIGIT_NUM = 6;

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_BLANK = 2'd1,
        SCAN_SHOW  = 2'd2
    } scan_state_t;

    // Converts a 1=lit pattern into bus polarity.
    function automatic seg8_t seg_polarity(input seg8_t pat, input bit active_low);
        return active_low ? ~pat : pat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_scan.sv
// ============================================================================
// Module      : seg7_scan
// Description : Time-multiplexed 7-segment scanner with per-frame shadow latch.
//               Optional PWM dimming when SEG7_SCAN_DIMMING_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan
    import datatype_package::*;
#(
    parameter int DIGIT_NUM      = SEG7_DIGIT_NUM,
    parameter int DIGIT_CYCLES   = 50_000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  seg8_t                seg_i [DIGIT_NUM],
`ifdef SEG7_SCAN_DIMMING_EN
    input  logic [3:0]           bright_i,
`endif
    output logic [7:0]           seg_o,
    output logic [DIGIT_NUM-1:0] dig_o,
    output logic                 frame_o
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);
    localparam int IDX_W = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1;

    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_END  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGIT_NUM - 1);

    localparam seg8_t                SEG_DARK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGIT_NUM-1:0] DIG_DARK = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    scan_state_t      state;
    scan_state_t      state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_d;
    logic             load;
    seg8_t            shadow [DIGIT_NUM];
    seg8_t            pattern_d;
    logic             lit_ok;
    logic [DIGIT_NUM-1:0] dig_vec;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        load    = 1'b0;
        case (state)
            SCAN_IDLE: begin
                if (en_i) begin
                    state_d = SCAN_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            SCAN_BLANK: begin
                cnt_d = cnt + 1'b1;
                if (cnt == BLANK_END) begin
                    state_d = SCAN_SHOW;
                end
            end
            SCAN_SHOW: begin
                if (cnt == SLOT_END) begin
                    cnt_d   = '0;
                    state_d = SCAN_BLANK;
                    if (idx == LAST_IDX) begin
                        idx_d = '0;
                        load  = 1'b1;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = SCAN_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
        // Disable overrides everything, including an end-of-frame reload.
        if (!en_i) begin
            state_d = SCAN_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            load    = 1'b0;
        end
    end

    // Outputs are registered from next-state values so they track the state register.
    always_comb begin
        pattern_d = load ? seg_i[idx_d] : shadow[idx_d];
    end

`ifdef SEG7_SCAN_DIMMING_EN
    logic [3:0] pwm;
    logic [3:0] pwm_d;

    always_comb begin
        pwm_d = pwm;
        if (state_d == SCAN_SHOW) begin
            pwm_d = (state == SCAN_SHOW) ? pwm + 4'd1 : 4'd0;
        end
        lit_ok = (pwm_d <= bright_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pwm <= 4'd0;
        end else begin
            pwm <= pwm_d;
        end
    end
`else
    always_comb begin
        lit_ok = 1'b1;
    end
`endif

    always_comb begin
        dig_vec = '0;
        if (state_d == SCAN_SHOW && lit_ok) begin
            dig_vec[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= SCAN_IDLE;
            cnt     <= '0;
            idx     <= '0;
            seg_o   <= SEG_DARK;
            dig_o   <= DIG_DARK;
            frame_o <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            idx     <= idx_d;
            frame_o <= load;
            seg_o   <= (state_d == SCAN_IDLE) ? SEG_DARK
                                              : seg_polarity(pattern_d, SEG_ACTIVE_LOW != 0);
            dig_o   <= (DIG_ACTIVE_LOW != 0) ? ~dig_vec : dig_vec;
        end
    end

    // Frame content survives a disable; it is reloaded on every restart anyway.
    always_ff @(posedge clk_i) begin
        if (load) begin
            shadow <= seg_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan.sv
// ============================================================================
// Module      : tb_seg7_scan
// Description : Self-checking bench for seg7_scan: time-based reference model
//               plus directed literal checks and randomized enable/data traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan;
    import datatype_package::*;

    localparam int DN    = 6;
    localparam int DC    = 8;
    localparam int BC    = 2;
    localparam int FRAME = DN * DC;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          en    = 1'b0;
    seg8_t         seg_in [DN];
    logic [7:0]    seg_out;
    logic [DN-1:0] dig_out;
    logic          frame_out;
`ifdef SEG7_SCAN_DIMMING_EN
    logic [3:0]    bright = 4'd15;
    logic [3:0]    m_bright;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seg7_scan #(
        .DIGIT_NUM      (DN),
        .DIGIT_CYCLES   (DC),
        .BLANK_CYCLES   (BC),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .en_i     (en),
        .seg_i    (seg_in),
`ifdef SEG7_SCAN_DIMMING_EN
        .bright_i (bright),
`endif
        .seg_o    (seg_out),
        .dig_o    (dig_out),
        .frame_o  (frame_out)
    );

    // Reference: t counts cycles since the scan started; digit and phase follow by division.
    bit          running;
    int unsigned t;
    seg8_t       m_shadow [DN];
    bit          m_frame;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            t       <= 0;
            m_frame <= 1'b0;
        end else begin
`ifdef SEG7_SCAN_DIMMING_EN
            m_bright <= bright;
`endif
            if (!en) begin
                running <= 1'b0;
                t       <= 0;
                m_frame <= 1'b0;
            end else if (!running) begin
                running  <= 1'b1;
                t        <= 0;
                m_shadow <= seg_in;
                m_frame  <= 1'b1;
            end else begin
                t       <= t + 1;
                m_frame <= ((t + 1) % FRAME == 0);
                if ((t + 1) % FRAME == 0) m_shadow <= seg_in;
            end
        end
    end

    function automatic logic [7:0] exp_seg();
        if (!running) return 8'hFF;
        return ~m_shadow[(t / DC) % DN];
    endfunction

    function automatic logic [DN-1:0] exp_dig();
        logic [DN-1:0] one;
        int ph;
        one = 1;
        if (!running) return '1;
        ph = int'(t % DC);
        if (ph < BC) return '1;
`ifdef SEG7_SCAN_DIMMING_EN
        if (((ph - BC) % 16) > int'(m_bright)) return '1;
`endif
        return ~(one << ((t / DC) % DN));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("model_seg",   32'(seg_out),   32'(exp_seg()));
            check("model_dig",   32'(dig_out),   32'(exp_dig()));
            check("model_frame", 32'(frame_out), 32'(m_frame));
        end
    end

    initial begin
        int cnt;
        for (int i = 0; i < DN; i++) seg_in[i] = seg8_t'(8'h01 << i);

        #1 rst_n = 1'b0;
        #2;
        check("reset_seg",   32'(seg_out),   32'h0000_00FF);
        check("reset_dig",   32'(dig_out),   32'h0000_003F);
        check("reset_frame", 32'(frame_out), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("idle_dig", 32'(dig_out), 32'h3F);

        // Start of scan.
        en = 1'b1;
        tick(1);
        check("start_frame", 32'(frame_out), 32'h1);
        check("start_dig",   32'(dig_out),   32'h3F);
        check("start_seg",   32'(seg_out),   32'hFE);
        tick(1);
        check("blank2_dig",   32'(dig_out),   32'h3F);
        check("blank2_frame", 32'(frame_out), 32'h0);
        tick(1);
        check("show0_dig", 32'(dig_out), 32'h3E);
        check("show0_seg", 32'(seg_out), 32'hFE);
        tick(6);
        check("blank1_seg", 32'(seg_out), 32'hFD);
        check("blank1_dig", 32'(dig_out), 32'h3F);
        tick(2);
        check("show1_dig", 32'(dig_out), 32'h3D);
        tick(37);
        check("pre_frame", 32'(frame_out), 32'h0);
        tick(1);
        check("frame2", 32'(frame_out), 32'h1);
        check("frame2_seg", 32'(seg_out), 32'hFE);

        // Frame coherence: change digit 0 data while digit 3 is showing.
        tick(26);
        seg_in[0] = 8'h7F;
        tick(22);
        check("frame3", 32'(frame_out), 32'h1);
        check("coherent_seg", 32'(seg_out), 32'h80);

        // Disable during digit 2 SHOW.
        tick(19);
        en = 1'b0;
        tick(1);
        check("dis_seg",   32'(seg_out),   32'hFF);
        check("dis_dig",   32'(dig_out),   32'h3F);
        check("dis_frame", 32'(frame_out), 32'h0);
        tick(2);
        en = 1'b1;
        tick(1);
        check("restart_frame", 32'(frame_out), 32'h1);
        check("restart_seg",   32'(seg_out),   32'h80);

        // Async reset during digit 4 SHOW, between clock edges.
        tick(35);
        #2 rst_n = 1'b0;
        #1;
        check("async_seg",   32'(seg_out),   32'hFF);
        check("async_dig",   32'(dig_out),   32'h3F);
        check("async_frame", 32'(frame_out), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("post_rst_frame", 32'(frame_out), 32'h1);
        check("post_rst_dig",   32'(dig_out),   32'h3F);

        // Disable coinciding with end of frame: no reload pulse.
        tick(47);
        en = 1'b0;
        tick(1);
        check("eof_dis_frame", 32'(frame_out), 32'h0);
        check("eof_dis_seg",   32'(seg_out),   32'hFF);
        tick(2);

`ifdef SEG7_SCAN_DIMMING_EN
        bright = 4'd3;
        en     = 1'b1;
        tick(1);
        for (int s = 0; s < 3; s++) begin
            cnt = 0;
            for (int k = 0; k < DC; k++) begin
                if (dig_out != 6'h3F) cnt++;
                if (k == DC - 1) bright = (s == 0) ? 4'd0 : 4'd15;
                tick(1);
            end
            check("dim_on_cycles", 32'(cnt), (s == 0) ? 32'd4 : (s == 1) ? 32'd1 : 32'd6);
        end
`endif

        // Randomized enable, data and (rarely) reset traffic.
        en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (en) begin
                if ($urandom_range(0, 199) == 0) en = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                en = 1'b1;
            end
            for (int i = 0; i < DN; i++) begin
                if ($urandom_range(0, 15) == 0) seg_in[i] = seg8_t'($urandom);
            end
`ifdef SEG7_SCAN_DIMMING_EN
            if ($urandom_range(0, 7) == 0) bright = 4'($urandom);
`endif
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        tick(1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed 7-segment display scanner. Sits downstream of `seg7_mux` and accepts its six parallel 8-bit segment patterns. Drives the shared segment bus and the per-digit enables of the physical display, one digit at a time. Each frame is latched into a shadow register, so the display never tears when the upstream message changes mid-scan.

## Interface
- `DIGIT_NUM`, 6: number of digits scanned.
- `DIGIT_CYCLES`, 50_000: clock cycles per digit slot; must exceed `BLANK_CYCLES`.
- `BLANK_CYCLES`, 500: leading dark cycles per slot (anti-ghosting); ≥1.
- `SEG_ACTIVE_LOW`, 1: 1 means `seg_o` is inverted (lit segment = 0).
- `DIG_ACTIVE_LOW`, 1: 1 means `dig_o` is inverted (enabled digit = 0).
- `clk_i` input, 1: system clock.
- `rst_n_i` input, 1: reset; asynchronous, active-low.
- `en_i` input, 1: scan enable; low turns the display dark.
- `seg_i` input, `seg8_t [DIGIT_NUM]`: segment patterns, 1 = lit, bit 7 = dp; element i maps to digit i.
- `bright_i` input, 4: brightness. Present only with `SEG7_SCAN_DIMMING_EN`.
- `seg_o` output, 8: segment bus, polarity per `SEG_ACTIVE_LOW`.
- `dig_o` output, `DIGIT_NUM`: digit enables, polarity per `DIG_ACTIVE_LOW`.
- `frame_o` output, 1: one-cycle pulse when a new frame is latched.

## Operation
- States:
  - IDLE: dark.
  - BLANK: all digits off; `seg_o` already shows the current digit's pattern.
  - SHOW: one digit enabled.
- Registers:
  - `idx`: current digit, 0..`DIGIT_NUM`-1.
  - `cnt`: slot cycle counter, 0..`DIGIT_CYCLES`-1.
  - `shadow[DIGIT_NUM]`: latched frame.
- IDLE → BLANK at an edge where `en_i`=1. On that edge: `idx`←0, `cnt`←0, `shadow`←`seg_i`, `frame_o`←1.
- BLANK holds while `cnt` < `BLANK_CYCLES`. At `cnt` = `BLANK_CYCLES`, go to SHOW.
- SHOW holds until `cnt` = `DIGIT_CYCLES`-1. At that edge, `cnt`←0 and state → BLANK. Then:
  - If `idx` = `DIGIT_NUM`-1: `idx`←0, `shadow`←`seg_i`, `frame_o`←1.
  - Otherwise: `idx`←`idx`+1.
- `en_i`=0 sampled in any state: next state is IDLE, counters are cleared, outputs go dark. `shadow` is retained but reloaded on restart.
- Output coding:
  - `seg_o` = `shadow[idx]` in BLANK/SHOW, all-off in IDLE.
  - `dig_o` has only bit `idx` active, and only in SHOW.
- Polarity inversion is applied last, at the output registers.
- Counters wrap only via the explicit compares above; there is no free-running overflow.
- Async reset asserted mid-frame: every output goes to its dark value immediately, without waiting for a clock edge.

## Timing
- All outputs are registered.
- Reset values:
  - `seg_o` = 8'hFF if `SEG_ACTIVE_LOW`, else 8'h00.
  - `dig_o` = all-ones if `DIG_ACTIVE_LOW`, else all-zeros.
  - `frame_o` = 0; state IDLE; `idx`, `cnt` = 0.
- Latency: 1 cycle from the `en_i` sample to BLANK outputs and the `frame_o` pulse. Digit 0 is enabled `BLANK_CYCLES` cycles later.
- Slot length: exactly `DIGIT_CYCLES` cycles, with `BLANK_CYCLES` dark then `DIGIT_CYCLES`-`BLANK_CYCLES` lit.
- Frame period: `DIGIT_NUM`×`DIGIT_CYCLES`. `frame_o` pulses are spaced exactly one frame period apart.
- `seg_i` is sampled only on the `frame_o` edge. Changes at any other time appear from the next frame.
- Simultaneous `en_i`=0 and end-of-frame: disable wins, with no reload and no `frame_o`.

## Configuration
- `SEG7_SCAN_DIMMING_EN` defined:
  - Adds `bright_i` and a 4-bit PWM counter, cleared on SHOW entry and incremented every SHOW cycle.
  - The digit is enabled only while PWM count ≤ `bright_i`, giving a duty of (`bright_i`+1)/16; 15 is full on.
  - `bright_i` is sampled every cycle.
  - Only `dig_o` is gated; `seg_o` is unaffected.
- Macro undefined: no `bright_i` port, no PWM logic; the digit is enabled for the whole SHOW phase.

## Structure
- Add to `datatype_package`:
  - `typedef logic [7:0] seg8_t`
  - `localparam int SEG7_DIGIT_NUM = 6` (default for `DIGIT_NUM`)
  - `typedef enum { SCAN_IDLE, SCAN_BLANK, SCAN_SHOW } scan_state_t`
- No sub-module; the PWM is inline under the macro.

## Test plan
Bench parameters: `DIGIT_NUM`=6, `DIGIT_CYCLES`=8, `BLANK_CYCLES`=2, both polarities active-low. `seg_i` = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20}.
- Reset: `rst_n_i`=0 → `seg_o`=8'hFF, `dig_o`=6'h3F, `frame_o`=0.
- Start scan: raise `en_i` → next cycle `frame_o`=1 and `dig_o`=6'h3F for 2 cycles. Then 6 cycles of `dig_o`=6'h3E with `seg_o`=8'hFE. Digit 1 follows with `dig_o`=6'h3D, `seg_o`=8'hFD. `frame_o` repeats every 48 cycles.
- Frame coherence: set `seg_i[0]`=8'h7F during digit 3 → digit 0 still shows 8'hFE until after the next `frame_o`, then shows 8'h80.
- Disable mid-SHOW: drop `en_i` during digit 2 → next cycle `seg_o`=8'hFF, `dig_o`=6'h3F. Re-raise → restart at digit 0 with a `frame_o` pulse.
- Async reset during digit 4: assert `rst_n_i` between clock edges → outputs go dark immediately. After release, state is IDLE.
- Dimming (macro on): `bright_i`=3 → digit active 4 of 6 SHOW cycles. `bright_i`=0 → 1 of 6. `bright_i`=15 → 6 of 6.
